// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low segment codes (bit6=a .. bit0=g) and digit constants.
// Used by both the display encoder and the cat2bits_32 receive-side decoder.
package seg7_pkg;

    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0000100;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b1100000;
    localparam logic [6:0] SEG_C = 7'b0110001;
    localparam logic [6:0] SEG_D = 7'b1000010;
    localparam logic [6:0] SEG_E = 7'b0110000;
    localparam logic [6:0] SEG_F = 7'b0111000;

    localparam logic [7:0]  AN_BLANK   = 8'hFF;
    localparam int unsigned NUM_DIGITS = 8;

endpackage

// File: rtl/cat2hex_4.sv
// Combinational decode of an active-low 7-segment pattern back to its hex nibble.
// Patterns outside the 16 hex glyphs report legal_o=0 with hex_o=0.
module cat2hex_4
    import seg7_pkg::*;
(
    input  logic [6:0] cat_i,
    output logic [3:0] hex_o,
    output logic       legal_o
);

    always_comb begin
        hex_o   = 4'h0;
        legal_o = 1'b1;
        case (cat_i)
            SEG_0:   hex_o = 4'h0;
            SEG_1:   hex_o = 4'h1;
            SEG_2:   hex_o = 4'h2;
            SEG_3:   hex_o = 4'h3;
            SEG_4:   hex_o = 4'h4;
            SEG_5:   hex_o = 4'h5;
            SEG_6:   hex_o = 4'h6;
            SEG_7:   hex_o = 4'h7;
            SEG_8:   hex_o = 4'h8;
            SEG_9:   hex_o = 4'h9;
            SEG_A:   hex_o = 4'hA;
            SEG_B:   hex_o = 4'hB;
            SEG_C:   hex_o = 4'hC;
            SEG_D:   hex_o = 4'hD;
            SEG_E:   hex_o = 4'hE;
            SEG_F:   hex_o = 4'hF;
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/cat2bits_32.sv
// Receive side of the 8-digit multiplexed 7-segment interface: waits for each digit to settle,
// decodes it, and publishes the 32-bit word once all eight digits have been seen.
module cat2bits_32
    import seg7_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_i,
    input  logic [6:0]  CAT_i,
    input  logic [7:0]  AN_i,
    output logic [31:0] data_o,
    output logic        valid_o,
    output logic        frame_o,
    output logic        err_o
);

    localparam int unsigned CntW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(SETTLE_CYCLES);
    localparam logic [CntW-1:0] CntCap = CntW'(SETTLE_CYCLES - 1);

    logic [7:0]      an_q, an_p;
    logic [6:0]      cat_q, cat_p;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [7:0]      mask_q;
    logic [31:0]     shadow_q;

    logic [3:0]  hex;
    logic        legal;
    logic [7:0]  an_sel;
    logic        stable, capture, one_hot, blank, wr, bad, done;
    logic [31:0] shadow_merged;

    cat2hex_4 u_cat2hex (
        .cat_i   (cat_q),
        .hex_o   (hex),
        .legal_o (legal)
    );

    always_comb begin
        an_sel  = ~an_q;
        stable  = (an_q == an_p) && (cat_q == cat_p);
        capture = stable && (cnt_q == CntCap);
        blank   = (an_q == AN_BLANK);
        one_hot = (an_sel != 8'h00) && ((an_sel & (an_sel - 8'h01)) == 8'h00);
        wr      = capture && one_hot && legal;
        bad     = capture && !blank && !(one_hot && legal);
        done    = wr && ((mask_q | an_sel) == 8'hFF);

        cnt_d = cnt_q;
        if (!stable) begin
            cnt_d = '0;
        end else if (cnt_q < CntMax) begin
            cnt_d = cnt_q + 1'b1;
        end

        shadow_merged = shadow_q;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (an_sel[k]) begin
                shadow_merged[4*k +: 4] = hex;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            an_q     <= AN_BLANK;
            an_p     <= AN_BLANK;
            cat_q    <= 7'h7F;
            cat_p    <= 7'h7F;
            cnt_q    <= '0;
            mask_q   <= 8'h00;
            shadow_q <= 32'h0;
            data_o   <= 32'h0;
            valid_o  <= 1'b0;
            frame_o  <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            an_q    <= AN_i;
            an_p    <= an_q;
            cat_q   <= CAT_i;
            cat_p   <= cat_q;
            cnt_q   <= cnt_d;
            frame_o <= done;
            err_o   <= bad;
            if (wr) begin
                shadow_q <= shadow_merged;
                mask_q   <= done ? 8'h00 : (mask_q | an_sel);
            end
            // Shadow is retained after a frame; only the mask restarts.
            if (done) begin
                data_o  <= shadow_merged;
                valid_o <= 1'b1;
            end
        end
    end

endmodule

// File: doc/cat2bits_32.md
Name: cat2bits_32

Overview:
- Receive side of the team's 8-digit multiplexed 7-segment interface.
- Watches active-low anode strobes (AN) and active-low cathodes (CAT), waits for each digit to settle, and decodes the segment pattern back to a hex nibble.
- Assembles the eight nibbles into the 32-bit word being displayed.
- Used as an on-chip loopback/self-check monitor of the display driver, and as a decoder for scanned displays from other boards.

Parameters:
- SETTLE_CYCLES, 16, consecutive unchanged-sample cycles needed before a digit is captured; legal range >= 1.

Ports:
- clk  input  1  system clock
- rst_i  input  1  synchronous, active-high reset
- CAT_i  input  7  active-low segments, bit6=a ... bit0=g
- AN_i  input  8  active-low digit enables, bit k = digit k (nibble k, bits 4k+3:4k)
- data_o  output  32  last complete decoded word
- valid_o  output  1  sticky; high once at least one full frame has been decoded since reset
- frame_o  output  1  1-cycle pulse when data_o is updated
- err_o  output  1  1-cycle pulse on a settled but illegal pattern

Behaviour:
- Clock and reset: one clock, clk. Reset rst_i is synchronous and active-high, level-sensitive, and takes priority over all other logic.
- Reset values:
  - data_o=0, valid_o=0, frame_o=0, err_o=0.
  - Capture mask=0, shadow register=0, settle counter=0.
  - Sample stages AN_q/AN_p=8'hFF, CAT_q/CAT_p=7'h7F.
- Input pipeline: two register stages. AN_q/CAT_q sample the inputs; AN_p/CAT_p hold the previous sample. No synchronizer is required; the inputs are same-clock-domain.
- Stable condition: AN_q==AN_p and CAT_q==CAT_p.
- Settle counter cnt, width clog2(SETTLE_CYCLES+1):
  - not stable -> cnt<=0;
  - stable and cnt<SETTLE_CYCLES -> cnt<=cnt+1;
  - saturates at SETTLE_CYCLES.
- Capture event: stable and cnt==SETTLE_CYCLES-1. Fires exactly once per stable run.
- Latency: an input change held steady produces its capture on clock edge SETTLE_CYCLES+2 after the change (18 edges at the default).
- On a capture event, classify AN_q:
  - AN_q==8'hFF (blanked): ignored; no write, no error.
  - Exactly one zero bit at position k:
    - CAT_q is a legal code -> shadow nibble k <= decoded value and mask[k] <= 1.
    - CAT_q is illegal -> err_o pulse; shadow and mask unchanged.
  - Any other AN_q (multiple zeros): err_o pulse; no write.
- Repeated digit before the frame completes: the nibble is overwritten and the mask is unchanged.
- Frame completion: a capture makes (mask | new bit)==8'hFF. In the same edge:
  - data_o <= shadow with the new nibble merged in;
  - frame_o <= 1 for one cycle;
  - valid_o <= 1;
  - mask <= 0.
  - The shadow register keeps its contents.
- Digit order is irrelevant; any permutation of the 8 digits completes a frame.
- Reset mid-frame discards the partial mask, the shadow register and data_o.
- err_o and frame_o are never both high (a capture is either legal or illegal).

Decomposition:
- Package seg7_pkg, shared with the display encoder:
  - SEG_0..SEG_F 7-bit active-low codes: 0:0000001 1:1001111 2:0010010 3:0000110 4:1001100 5:0100100 6:0100000 7:0001111 8:0000000 9:0000100 A:0001000 b:1100000 C:0110001 d:1000010 E:0110000 F:0111000;
  - AN_BLANK=8'hFF;
  - NUM_DIGITS=8.
- Sub-module cat2hex_4: combinational. CAT[6:0] -> hex[3:0] plus legal flag. Any of the other 112 codes gives legal=0, hex=0.
- Top-level holds the pipeline, settle counter, mask/shadow and output registers.

Test Plan:
- Reset then idle with AN=FF, CAT=7F for 100 cycles -> data_o=0, valid_o=0, no frame_o/err_o pulses.
- Drive the digits in order with SETTLE_CYCLES=16 and 30 cycles per digit: digit 0..7 = F,E,D,C,B,A,9,8 (AN_i=~(1<<k), CAT_i=SEG code) -> after digit 7 settles, data_o=32'h89ABCDEF, frame_o single pulse, valid_o=1.
- Latency check: AN/CAT change to digit 3 / SEG_5 at edge t, held -> the shadow write and the mask bit appear at edge t+18. A change after 17 cycles resets cnt and gives no capture.
- Glitch rejection: toggle CAT every 5 cycles for 100 cycles -> no capture, no err_o. Then a settled illegal CAT=7'b1111111 on digit 2 -> one err_o pulse, mask bit 2 still 0.
- Bad anode: settled AN_i=8'b11110011 -> one err_o pulse. Digit 0 repeated with SEG_3 then SEG_7 before completion -> nibble 0 = 7 in the next data_o.
- rst_i asserted after 5 of 8 digits, then a full frame of 32'h12345678 -> data_o=32'h12345678. The pre-reset digits do not contribute to the frame, and frame_o pulses only after all 8 new digits.
